// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared pipeline constants and IF/ID bundle type
package fetch_stage_pkg;

   localparam int          PIPE_PC_WIDTH    = 32;
   localparam logic [31:0] NOP_INST         = 32'h0000_0000;
   localparam logic [31:0] PC_STEP          = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // IF/ID register contents, consumed as-is by decode
   typedef struct packed {
      logic [31:0]              inst;
      logic [PIPE_PC_WIDTH-1:0] pc_plus4;
      logic                     valid;
   } ifid_t;

   // Branch targets are word addresses; low byte-offset bits are dropped
   function automatic logic [PIPE_PC_WIDTH-1:0] word_align(input logic [PIPE_PC_WIDTH-1:0] addr);
      return {addr[PIPE_PC_WIDTH-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_stage_pc_next_sel.sv
// rtl/fetch_stage_pc_next_sel.sv - next-PC priority mux: redirect, pending, sequential
module pc_next_sel
   import fetch_stage_pkg::*;
#(
   parameter int PC_WIDTH = PIPE_PC_WIDTH
) (
   input  logic                redirect_valid,
   input  logic [PC_WIDTH-1:0] redirect_target,
   input  logic                pend_valid,
   input  logic [PC_WIDTH-1:0] pend_target,
   input  logic [PC_WIDTH-1:0] pc_plus4,
   output logic [PC_WIDTH-1:0] next_pc
);

   // A fresh redirect is newer than anything buffered, so it wins
   always_comb begin
      next_pc = pc_plus4;
      if (redirect_valid) begin
         next_pc = {redirect_target[PC_WIDTH-1:2], 2'b00};
      end else if (pend_valid) begin
         next_pc = pend_target;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, IF/ID register, pending redirect buffer
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int                  PC_WIDTH     = PIPE_PC_WIDTH,
   parameter int                  INST_NUM_BIT = 8,
   parameter logic [PC_WIDTH-1:0] RESET_PC     = DEFAULT_RESET_PC
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    stall,
   input  logic                    redirect_valid,
   input  logic [PC_WIDTH-1:0]     redirect_target,
   output logic [INST_NUM_BIT-1:0] inst_addr,
   input  logic [31:0]             instruction,
   output logic [PC_WIDTH-1:0]     pc,
   output logic [31:0]             ifid_inst,
   output logic [PC_WIDTH-1:0]     ifid_pc_plus4,
   output logic                    ifid_valid
);

   logic [PC_WIDTH-1:0] pc_q, pc_d;
   ifid_t               ifid_q, ifid_d;
   logic                pend_valid_q, pend_valid_d;
   logic [PC_WIDTH-1:0] pend_target_q, pend_target_d;
   logic [PC_WIDTH-1:0] pc_plus4;
   logic [PC_WIDTH-1:0] next_pc;

   // Carry out of the PC adder is discarded, so fetch wraps at the top of memory
   assign pc_plus4  = pc_q + PC_STEP[PC_WIDTH-1:0];
   assign inst_addr = pc_q[INST_NUM_BIT+1:2];

   pc_next_sel #(
      .PC_WIDTH(PC_WIDTH)
   ) u_pc_next_sel (
      .redirect_valid (redirect_valid),
      .redirect_target(redirect_target),
      .pend_valid     (pend_valid_q),
      .pend_target    (pend_target_q),
      .pc_plus4       (pc_plus4),
      .next_pc        (next_pc)
   );

   // Advance on unstalled cycles; while stalled, park the newest redirect so it is not lost.
   // The delay-slot instruction is never flushed: it enters IF/ID on the redirect edge.
   always_comb begin
      pc_d          = pc_q;
      ifid_d        = ifid_q;
      pend_valid_d  = pend_valid_q;
      pend_target_d = pend_target_q;
      if (!stall) begin
         pc_d            = next_pc;
         ifid_d.inst     = instruction;
         ifid_d.pc_plus4 = pc_plus4;
         ifid_d.valid    = 1'b1;
         pend_valid_d    = 1'b0;
      end else if (redirect_valid) begin
         pend_valid_d  = 1'b1;
         pend_target_d = {redirect_target[PC_WIDTH-1:2], 2'b00};
      end
   end

   // Fetch state; reset clears everything immediately
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q            <= RESET_PC;
         ifid_q.inst     <= NOP_INST;
         ifid_q.pc_plus4 <= '0;
         ifid_q.valid    <= 1'b0;
         pend_valid_q    <= 1'b0;
         pend_target_q   <= '0;
      end else begin
         pc_q          <= pc_d;
         ifid_q        <= ifid_d;
         pend_valid_q  <= pend_valid_d;
         pend_target_q <= pend_target_d;
      end
   end

   assign pc            = pc_q;
   assign ifid_inst     = ifid_q.inst;
   assign ifid_pc_plus4 = ifid_q.pc_plus4;
   assign ifid_valid    = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed table-driven bench for fetch_stage
module tb_fetch_stage;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic [7:0]  inst_addr;
   logic [31:0] instruction;
   logic [31:0] pc;
   logic [31:0] ifid_inst;
   logic [31:0] ifid_pc_plus4;
   logic        ifid_valid;

   logic [31:0] mem [256];

   int total = 0;
   int bad   = 0;

   fetch_stage dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_target(redirect_target),
      .inst_addr      (inst_addr),
      .instruction    (instruction),
      .pc             (pc),
      .ifid_inst      (ifid_inst),
      .ifid_pc_plus4  (ifid_pc_plus4),
      .ifid_valid     (ifid_valid)
   );

   assign instruction = mem[inst_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic        rv;
      logic [31:0] target;
      logic [31:0] exp_pc;
      logic [31:0] exp_inst;
      logic [31:0] exp_pp4;
      logic        exp_valid;
      logic        exp_pend;
   } vec_t;

   vec_t vecs [21];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_inst,
                          input logic [31:0] e_pp4, input logic e_valid, input logic e_pend);
      chk({tag, ".pc"}, pc, e_pc);
      chk({tag, ".inst_addr"}, {24'h0, inst_addr}, {24'h0, e_pc[9:2]});
      chk({tag, ".ifid_inst"}, ifid_inst, e_inst);
      chk({tag, ".ifid_pc_plus4"}, ifid_pc_plus4, e_pp4);
      chk({tag, ".ifid_valid"}, {31'h0, ifid_valid}, {31'h0, e_valid});
      chk({tag, ".pend_valid"}, {31'h0, dut.pend_valid_q}, {31'h0, e_pend});
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
      mem[0]  = 32'h3C01_6165;
      mem[1]  = 32'h3421_6165;
      mem[2]  = 32'h0001_4020;
      mem[13] = 32'h2007_0200;
      mem[16] = 32'h23BD_FFF4;

      //         stall rv  target        pc            inst          pp4           v     pend
      vecs[0]  = '{1'b0, 1'b0, 32'h0,        32'h4,        32'h3C016165, 32'h4,  1'b1, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 32'h0,        32'h8,        32'h34216165, 32'h8,  1'b1, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 32'h0,        32'h8,        32'h34216165, 32'h8,  1'b1, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 32'h0,        32'h8,        32'h34216165, 32'h8,  1'b1, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 32'h0,        32'hC,        32'h00014020, 32'hC,  1'b1, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 32'h30,       32'h30,       32'h10000003, 32'h10, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 32'h0,        32'h34,       32'h1000000C, 32'h34, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 32'h40,       32'h40,       32'h20070200, 32'h38, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 32'h0,        32'h44,       32'h23BDFFF4, 32'h44, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 1'b1, 32'h60,       32'h44,       32'h23BDFFF4, 32'h44, 1'b1, 1'b1};
      vecs[10] = '{1'b0, 1'b0, 32'h0,        32'h60,       32'h10000011, 32'h48, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 32'h43,       32'h40,       32'h10000018, 32'h64, 1'b1, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 32'h0,        32'h44,       32'h23BDFFF4, 32'h44, 1'b1, 1'b0};
      vecs[13] = '{1'b1, 1'b1, 32'h80,       32'h44,       32'h23BDFFF4, 32'h44, 1'b1, 1'b1};
      vecs[14] = '{1'b1, 1'b1, 32'h93,       32'h44,       32'h23BDFFF4, 32'h44, 1'b1, 1'b1};
      vecs[15] = '{1'b1, 1'b0, 32'h0,        32'h44,       32'h23BDFFF4, 32'h44, 1'b1, 1'b1};
      vecs[16] = '{1'b0, 1'b0, 32'h0,        32'h90,       32'h10000011, 32'h48, 1'b1, 1'b0};
      vecs[17] = '{1'b0, 1'b1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h10000024, 32'h94, 1'b1, 1'b0};
      vecs[18] = '{1'b0, 1'b0, 32'h0,        32'h0,        32'h100000FF, 32'h0,  1'b1, 1'b0};
      vecs[19] = '{1'b1, 1'b1, 32'h20,       32'h0,        32'h100000FF, 32'h0,  1'b1, 1'b1};
      vecs[20] = '{1'b0, 1'b1, 32'h28,       32'h28,       32'h3C016165, 32'h4,  1'b1, 1'b0};

      reset           = 1'b0;
      stall           = 1'b0;
      redirect_valid  = 1'b0;
      redirect_target = 32'h0;

      repeat (2) @(posedge clk);
      #1;
      chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 21; i++) begin
         stall           = vecs[i].stall;
         redirect_valid  = vecs[i].rv;
         redirect_target = vecs[i].target;
         @(posedge clk);
         #1;
         chk_all($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_inst,
                 vecs[i].exp_pp4, vecs[i].exp_valid, vecs[i].exp_pend);
      end

      // Build pc=0x5C with a pending redirect, then reset between edges
      stall = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h5C;
      @(posedge clk); #1;
      chk("pre_reset.pc", pc, 32'h5C);
      stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h70;
      @(posedge clk); #1;
      chk_all("pre_reset", 32'h5C, 32'h1000000A, 32'h2C, 1'b1, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      chk_all("async_reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
      @(negedge clk);
      chk_all("reset_hold", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      reset = 1'b1;
      @(posedge clk); #1;
      chk_all("first_edge", 32'h4, 32'h3C016165, 32'h4, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline with architectural branch delay slots. It owns the program counter and drives the word address into the combinational `InstructionMemory`. It registers the returned instruction into the IF/ID pipeline register and applies stalls and control-flow redirects from the decode stage. A one-entry pending-redirect buffer makes sure a redirect is never lost while fetch is stalled.

## Interface
- `PC_WIDTH`, 32, width of the PC and of all address ports.
- `INST_NUM_BIT`, 8, width of the instruction-memory word address.
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `clk` input 1: the only clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low; clears all state immediately when low.
- `stall` input 1: hold the PC and IF/ID (load-use or other downstream hazard).
- `redirect_valid` input 1: decode has resolved a taken branch, jump, jal or jr this cycle.
- `redirect_target` input PC_WIDTH: byte address of the new fetch target.
- `inst_addr` output INST_NUM_BIT: word address to `InstructionMemory`.
- `instruction` input 32: combinational read data from `InstructionMemory`.
- `pc` output PC_WIDTH: current fetch PC.
- `ifid_inst` output 32: registered instruction for decode.
- `ifid_pc_plus4` output PC_WIDTH: registered PC+4 of that instruction (jal link value).
- `ifid_valid` output 1: IF/ID holds a fetched instruction.

## Operation
- `inst_addr = pc[INST_NUM_BIT+1:2]`, combinational. Higher PC bits are truncated, so addresses wrap modulo 4·2^INST_NUM_BIT. Out-of-range words read as 0 (nop) from memory.
- Reset values:
  - `pc` = RESET_PC.
  - `ifid_inst` = 32'h0 (nop).
  - `ifid_pc_plus4` = 0.
  - `ifid_valid` = 0.
  - `pend_valid` = 0 and `pend_target` = 0.
- Cycle with `stall`=0:
  - IF/ID loads `instruction`, `pc+4`, and `ifid_valid`=1.
  - Next PC priority: `redirect_valid` → `redirect_target`; else `pend_valid` → `pend_target`; else `pc+4`.
  - `pend_valid` clears.
- Cycle with `stall`=1:
  - `pc` and IF/ID hold.
  - If `redirect_valid`=1, `pend_target` ← `redirect_target` and `pend_valid` ← 1. A newer redirect overwrites an older pending one.
- Delay slot:
  - No flush ever occurs.
  - When decode raises `redirect_valid` for the branch in ID, IF holds the delay-slot instruction (branch PC+4).
  - That instruction enters IF/ID on the same edge that loads `pc` with the target.
- Targets are word-aligned by construction: `redirect_target[1:0]` is ignored and forced to 2'b00 when loaded.
- PC+4 arithmetic is modulo 2^PC_WIDTH; the carry is discarded.

## Timing
- Memory read is combinational: `instruction` is valid in the same cycle as `pc`.
- IF→ID latency: 1 cycle.
- A redirect sampled at edge N puts the target in `pc` after edge N (unstalled). The target instruction appears on `ifid_inst` after edge N+1.
- A pending redirect takes effect at the first unstalled edge.
- Reset asserted mid-operation: all outputs and pending state go to reset values asynchronously, without waiting for an edge.
- First edge after reset release: IF/ID captures word `RESET_PC>>2`, and `pc` becomes RESET_PC+4.
- Stall and redirect in the same cycle: stall wins for `pc`/IF/ID; the redirect is buffered.

## Structure
- The shared pipeline package holds:
  - `NOP_INST` = 32'h0.
  - `PC_STEP` = 4.
  - The default `RESET_PC`.
  - The IF/ID bundle typedef (`inst`, `pc_plus4`, `valid`), so decode can consume the same type.
- One natural sub-module, `pc_next_sel`: a combinational next-PC priority mux over redirect, pending and PC+4. All state stays in `fetch_stage`.

## Test plan
- **Reset and sequential fetch.** Release reset, no stall, no redirect, 3 edges. Required:
  - `inst_addr` 0,1,2,3.
  - `ifid_inst` 0x3C016165, 0x34216165, 0x00014020.
  - `ifid_pc_plus4` 4, 8, 0xC.
- **Delay-slot jal.** Assert `redirect_valid` with target 0x40 while `pc`=0x34. Required:
  - Next `ifid_inst` = 0x20070200 (word 13, the delay slot).
  - Then 0x23BDFFF4 (word 16).
  - `pc` = 0x40, then 0x44.
- **Stall hold.** Assert `stall` for 2 cycles at `pc`=0x08. Required:
  - `pc` stays 0x08 and `ifid_inst` stays 0x34216165.
  - Fetch resumes with 0x00014020.
- **Redirect during stall.** Apply `stall`=1 and `redirect_valid`=1 (target 0x60) for one cycle, then `stall`=0 with `redirect_valid`=0. Required:
  - `pc` holds during the stall.
  - `pc`=0x60 after the release edge.
  - `pend_valid` clears.
- **Misaligned target.** Redirect with target 0x43. Required: `pc`=0x40 and `inst_addr`=16.
- **Async reset mid-run.** Pull `reset` low between edges while `pc`=0x5C and `ifid_valid`=1 with a pending redirect. Required: `pc`=0, `ifid_valid`=0, `ifid_inst`=0 and `pend_valid`=0, all before the next edge.
